// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA scan-out of a 320x240 8-bit grayscale buffer.
// Each source pixel is doubled horizontally and vertically. Pixels are read
// through a fixed 1-cycle-latency RAM read port, and the result is driven as
// gray on the R/G/B buses.
// The timing generator and the 3-stage read pipeline never stall.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_pattern input. When that
// input is high, the pixel becomes an XOR checker (h_cnt[9:2] ^ v_cnt[9:2])
// instead of the buffer data.
module vga_frame_reader #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int SRC_W  = 320
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  input  logic [7:0]  rd_data,
  output logic [16:0] rd_address,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vblank,
  output logic        frame_end
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [16:0] STRIDE  = 17'(SRC_W);

  // Source address of a screen position: both coordinates halved for 2x doubling.
  function automatic logic [16:0] src_addr(input logic [9:0] h, input logic [9:0] v);
    logic [16:0] row;
    logic [16:0] col;
    row = {8'd0, v[9:1]};
    col = {8'd0, h[9:1]};
    return row * STRIDE + col;
  endfunction

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;

  logic       vis_p0, hs_p0, vs_p0, en_p0;
  logic       vis_p1, hs_p1, vs_p1, en_p1;
  logic       vis_p2, hs_p2, vs_p2, en_p2;
  logic [7:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
  logic       tp_p0, tp_p1, tp_p2;
  logic [7:0] pat_p0, pat_p1, pat_p2;
`endif

  // Free-running pixel/line counters; the line counter advances on pixel wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) v_cnt <= '0;
      else                 v_cnt <= v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // ---- stage 0: decode visibility and sync from the counters ----
  assign vis_p0 = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
  assign hs_p0  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_p0  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
  assign en_p0  = enable;

`ifdef VGA_TEST_PATTERN_EN
  assign tp_p0  = test_pattern;
  assign pat_p0 = h_cnt[9:2] ^ v_cnt[9:2];
`endif

  // Blanking status stays in counter timing so the controller sees it undelayed.
  assign vblank     = (v_cnt >= V_VIS_C);
  assign frame_end  = (h_cnt == 10'd0) && (v_cnt == V_VIS_C);
  assign vga_sync_n = 1'b0;

  // ---- stage 1: issue the read address; hold it outside the visible area ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_address <= '0;
      vis_p1     <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
      en_p1      <= 1'b0;
    end else begin
      if (vis_p0) rd_address <= src_addr(h_cnt, v_cnt);
      vis_p1 <= vis_p0;
      hs_p1  <= hs_p0;
      vs_p1  <= vs_p0;
      en_p1  <= en_p0;
    end
  end

  // ---- stage 2: RAM data arrives; carry the control bits one more cycle ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis_p2 <= 1'b0;
      hs_p2  <= 1'b1;
      vs_p2  <= 1'b1;
      en_p2  <= 1'b0;
    end else begin
      vis_p2 <= vis_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      en_p2  <= en_p1;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  // Test-pattern select and value follow the same two-stage path as enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tp_p1  <= 1'b0;
      tp_p2  <= 1'b0;
      pat_p1 <= '0;
      pat_p2 <= '0;
    end else begin
      tp_p1  <= tp_p0;
      tp_p2  <= tp_p1;
      pat_p1 <= pat_p0;
      pat_p2 <= pat_p1;
    end
  end

  // Pixel source: the generated pattern replaces buffer data when selected.
  always_comb begin
    pix_src = rd_data;
    if (tp_p2) pix_src = pat_p2;
  end
`else
  // Pixel source is always the buffer.
  always_comb begin
    pix_src = rd_data;
  end
`endif

  // ---- stage 3: register the DAC outputs, aligned with sync and blank ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= (vis_p2 && en_p2) ? pix_src : 8'd0;
      vga_hs      <= hs_p2;
      vga_vs      <= vs_p2;
      vga_blank_n <= vis_p2;
    end
  end

  assign vga_g = vga_r;
  assign vga_b = vga_r;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Testbench for vga_frame_reader using a reduced screen geometry so several
// whole frames fit in a short run. A behavioural model derives every output
// from the scan index (clock edges since reset release) using plain arithmetic.
module tb_vga_frame_reader;

  localparam int HV = 16, HF = 2, HS = 4, HB = 3, HT = HV + HF + HS + HB;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
  localparam int SW = 8;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        test_pattern = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic [16:0] rd_address;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vblank, frame_end;

  always #20 clk = ~clk;

  vga_frame_reader #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SRC_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .rd_data(rd_data),
    .rd_address(rd_address),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vblank(vblank),
    .frame_end(frame_end)
  );

  // Frame buffer model with one cycle of read latency.
  logic [7:0] mem [0:255];
  always @(posedge clk) rd_data <= mem[rd_address[7:0]];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hx(input int k); return k % HT; endfunction
  function automatic int vy(input int k); return (k / HT) % VT; endfunction
  function automatic bit vis_f(input int k); return (hx(k) < HV) && (vy(k) < VV); endfunction
  function automatic int addr_f(input int k); return (vy(k) / 2) * SW + hx(k) / 2; endfunction

  // Clock edges since reset release; the DUT counters sit at scan index cnt.
  int cnt = 0;
  always @(posedge clk) begin
    if (!rst) cnt <= 0;
    else      cnt <= cnt + 1;
  end

  bit en_hist [0:7];
  int exp_addr = 0;
  bit phase_a = 1'b0;
  int fe_cnt = 0, vb_cnt = 0, hs_lo = 0, vs_lo = 0, bl_hi = 0;
  int j, e_hs, e_vs, e_bl, e_px;

  // Compare process: mid-cycle, check every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_rd_address", rd_address, 0);
      check("rst_vga_r", vga_r, 0);
      check("rst_vga_hs", vga_hs, 1);
      check("rst_vga_vs", vga_vs, 1);
      check("rst_blank_n", vga_blank_n, 0);
      check("rst_vblank", vblank, 0);
      check("rst_frame_end", frame_end, 0);
      exp_addr = 0;
    end else begin
      en_hist[cnt % 8] = enable;
      if (cnt >= 1 && vis_f(cnt - 1)) exp_addr = addr_f(cnt - 1);
      check("rd_address", rd_address, exp_addr);
      check("vblank", vblank, int'(vy(cnt) >= VV));
      check("frame_end", frame_end, int'(hx(cnt) == 0 && vy(cnt) == VV));
      if (cnt >= 3) begin
        j    = cnt - 3;
        e_bl = int'(vis_f(j));
        e_hs = int'(!(hx(j) >= HV + HF && hx(j) < HV + HF + HS));
        e_vs = int'(!(vy(j) >= VV + VF && vy(j) < VV + VF + VS));
        e_px = (vis_f(j) && en_hist[j % 8]) ? int'(mem[addr_f(j)]) : 0;
      end else begin
        j = -1; e_bl = 0; e_hs = 1; e_vs = 1; e_px = 0;
      end
      check("vga_hs", vga_hs, e_hs);
      check("vga_vs", vga_vs, e_vs);
      check("vga_blank_n", vga_blank_n, e_bl);
      check("vga_r", vga_r, e_px);
      check("vga_g", vga_g, e_px);
      check("vga_b", vga_b, e_px);
      check("vga_sync_n", vga_sync_n, 0);
      if (phase_a) begin
        if (cnt < 3 * FT) begin
          fe_cnt += int'(frame_end);
          vb_cnt += int'(vblank);
        end
        if (cnt >= 3 && cnt < 3 + 3 * FT) begin
          hs_lo += int'(!vga_hs);
          vs_lo += int'(!vga_vs);
          bl_hi += int'(vga_blank_n);
        end
        if (j == 2)                   check("lit_line0_px2", vga_r, 1);
        if (j == HT + 3)              check("lit_line1_repeat", vga_r, 1);
        if (j == 2 * HT)              check("lit_line2_start", vga_r, 8);
        if (j == (VV - 1) * HT + HV - 1) check("lit_last_px", vga_r, 47);
        if (cnt - 1 == (VV - 1) * HT + HV - 1) check("lit_last_addr", rd_address, 47);
      end
    end
  end

  int n;
  bit found;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b0;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #5 rst = 1'b1;
    phase_a = 1'b1;

    // Three frames with an identity buffer and the display enabled.
    repeat (3 * FT + 3) @(posedge clk);
    #1 phase_a = 1'b0;
    check("frames_frame_end_pulses", fe_cnt, 3);
    check("frames_vblank_cycles", vb_cnt, 3 * 7 * 25);
    check("frames_hs_low_cycles", hs_lo, 3 * 19 * 4);
    check("frames_vs_low_cycles", vs_lo, 3 * 2 * 25);
    check("frames_blank_high_cycles", bl_hi, 3 * 16 * 12);

    // A full frame forced black.
    enable = 1'b0;
    repeat (FT + 10) @(posedge clk);

    // Random enable toggling, one decision per pixel.
    repeat (2 * FT) begin
      @(posedge clk);
      #1 enable = 1'($urandom_range(0, 1));
    end

    // Asynchronous reset in the middle of a visible line, between edges.
    enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < FT + 5; i++) begin
      @(posedge clk);
      #1;
      if (cnt % FT == 5 * HT + 7) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_reset_point", int'(found), 1);
    check("pre_reset_blank_n", vga_blank_n, 1);
    #4 rst = 1'b0;
    #1;
    check("async_rst_blank_n", vga_blank_n, 0);
    check("async_rst_hs", vga_hs, 1);
    check("async_rst_vga_r", vga_r, 0);
    check("async_rst_addr", rd_address, 0);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    repeat (2) @(posedge clk);
    #5 rst = 1'b1;
    n = 0;
    while (n < 20 && !vga_blank_n) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("blank_rise_after_release", n, 3);

    // Random buffer contents with random enable.
    repeat (2 * FT) begin
      @(posedge clk);
      #1 enable = 1'($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream consumer of the 320x240 8-bit grayscale output frame buffer that the zoom stages write.
- Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Reads the buffer through the RAM's second (read) port and drives 2x pixel/line-doubled grayscale on the DAC R/G/B buses.
- Exports vertical-blank status so the controller can start zoom passes between frames.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SRC_W, 320, source buffer width in pixels (row stride)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  reset; asynchronous, active-low
- enable  in  1  1 = show buffer; 0 = force black, timing keeps running
- rd_data  in  8  buffer read data; valid exactly 1 cycle after rd_address
- rd_address  out  17  buffer read address
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low
- vga_blank_n  out  1  1 during visible area
- vga_sync_n  out  1  constant 0
- vga_r  out  8  red
- vga_g  out  8  green
- vga_b  out  8  blue
- vblank  out  1  1 while v_cnt >= V_VIS (undelayed counter domain)
- frame_end  out  1  one-cycle pulse when v_cnt becomes V_VIS at h_cnt = 0

Behaviour:
- Reset (rst=0, async) values:
  - h_cnt, v_cnt, rd_address, vga_r/g/b, frame_end = 0.
  - vga_hs, vga_vs = 1; vga_blank_n = 0; vblank = 0.
  - All delay-pipeline registers take their inactive values.
- Counters:
  - h_cnt 0..799 (10 bits), increments every clk, wraps to 0.
  - v_cnt 0..524 (10 bits), increments when h_cnt wraps; wraps to 0 after 524.
- Stage 0 (counter cycle t), combinational:
  - vis = (h_cnt < 640) && (v_cnt < 480).
  - hs0 = !(656 <= h_cnt < 752).
  - vs0 = !(490 <= v_cnt < 492).
- Stage 1 (t+1): rd_address <= (v_cnt>>1)*SRC_W + (h_cnt>>1) when vis, else unchanged.
  - Arithmetic is 17-bit; maximum 239*320 + 319 = 76799, no overflow.
- Stage 2 (t+2): rd_data is valid.
- Stage 3 (t+3), outputs registered:
  - vga_r = vga_g = vga_b = (vis_d2 && enable_d2) ? rd_data : 0.
  - vga_hs, vga_vs, vga_blank_n = hs0, vs0, vis each delayed exactly 3 clocks, so sync, blank and data stay aligned.
- enable is sampled in stage 0 and carried through the same pipeline. Toggling it mid-line takes effect on the pixel whose counter cycle sampled it.
- Horizontal doubling: each source pixel is output on 2 consecutive clocks (rd_address holds across an even/odd h_cnt pair).
- Vertical doubling: lines 2k and 2k+1 re-read the same source row k.
- vblank and frame_end are in counter timing (not delayed).
  - frame_end asserts for exactly one cycle per frame, at h_cnt=0, v_cnt=480.
  - vblank falls at h_cnt=0, v_cnt=0.
- Reset mid-frame: all outputs go to their reset values immediately. After release, counting restarts at (0,0); the first visible pixel appears 3 clocks after release.
- No internal state machine beyond the counters and pipeline. The block never stalls; rd_data latency is fixed at 1.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_pattern (1 bit).
  - When test_pattern is 1 (sampled in stage 0, pipelined like enable), the pixel value is (h_cnt[9:2] ^ v_cnt[9:2]) in place of rd_data. This gives an 8-bit XOR checker/ramp on all three channels.
  - rd_address still updates normally.
- Undefined: the port does not exist; the pixel source is always rd_data.

Test Plan:
- Timing: release rst and run 2 frames -> vga_hs low exactly 96 clocks every 800; vga_vs low exactly 2 lines (1600 clocks) every 525 lines; vga_blank_n high 640 of every 800 clocks on lines 0..479 only.
- Address/doubling: model RAM with rd_data = rd_address[7:0], 1-cycle latency -> first visible line outputs 0,0,1,1,2,2,...; line 1 repeats line 0; line 2 starts at address 320 (output 0x40).
- Extreme pixel: at h_cnt=639, v_cnt=479 -> rd_address = 76799 one cycle later; the pixel appears on vga_r at the last visible clock of line 479.
- enable=0 over the whole frame -> vga_r/g/b = 0 everywhere; syncs and blank_n unchanged.
- frame_end: count pulses over 3 frames -> exactly 3, each at h_cnt=0, v_cnt=480; vblank high for 45 lines per frame.
- Async reset at h_cnt=300, v_cnt=100, between clock edges -> outputs reach reset values without a clock edge; after release, first vga_blank_n rise is 3 clocks later.
